// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helpers for the radix-2 divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring iteration, shift in a dividend bit and try to subtract the divisor
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  assign q_o   = {rem_i, msb_i} >= {2'b0, div_i};
  assign rem_o = (W+1)'(q_o ? {rem_i, msb_i} - {2'b0, div_i} : {rem_i, msb_i});
endmodule

// File: rtl/rad2_div_seq.sv
// rad2_div_seq: signed sequential restoring divider, one quotient bit per cycle
module rad2_div_seq
  import div_pkg::*;
#(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH_1-1:0] x1_i,
  input  logic [DATA_WIDTH_2-1:0] x2_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH_1-1:0] q_o,
  output logic [DATA_WIDTH_2-1:0] r_o,
  output logic                    div0_o,
  output logic                    ovf_o
);
  localparam int W1 = DATA_WIDTH_1;
  localparam int W2 = DATA_WIDTH_2;
  localparam int CW = cnt_w(W1);
  localparam logic [W1-1:0] MIN1 = {1'b1, {(W1-1){1'b0}}};
  state_t state, state_n;
  logic [W1-1:0] a_q, x1_q, x1_abs;
  logic [W2-1:0] b_q, x2_abs;
  logic [W2:0]   rem_q, rem_n;
  logic [CW-1:0] cnt_q;
  logic          qs_q, rs_q, d0_q, ov_q, q_bit;
  // unsigned magnitudes: MIN maps onto 2^(W-1), which still fits
  assign x1_abs = x1_i[W1-1] ? -x1_i : x1_i;
  assign x2_abs = x2_i[W2-1] ? -x2_i : x2_i;
  div_step #(.W(W2)) u_step (
    .rem_i(rem_q),
    .msb_i(a_q[W1-1]),
    .div_i(b_q),
    .rem_o(rem_n),
    .q_o  (q_bit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? CALC : IDLE)
            : state == CALC ? (cnt_q == '0 ? FIX : CALC)
            : state == FIX  ? DONE
            : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q    <= '0;
      x1_q   <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      qs_q   <= 1'b0;
      rs_q   <= 1'b0;
      d0_q   <= 1'b0;
      ov_q   <= 1'b0;
      q_o    <= '0;
      r_o    <= '0;
      div0_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q   <= x1_abs;
        x1_q  <= x1_i;
        b_q   <= x2_abs;
        rem_q <= '0;
        cnt_q <= CW'(W1 - 1);
        qs_q  <= x1_i[W1-1] ^ x2_i[W2-1];
        rs_q  <= x1_i[W1-1];
        d0_q  <= x2_i == '0;
        ov_q  <= x1_i == MIN1 && x2_i == '1;
      end
      if (state == CALC) begin
        rem_q <= rem_n;
        a_q   <= {a_q[W1-2:0], q_bit};
        cnt_q <= cnt_q - 1'b1;
      end
      // a_q now holds the quotient magnitude, rem_q the remainder magnitude
      if (state == FIX) begin
        q_o    <= d0_q ? '1 : ov_q ? MIN1 : qs_q ? -a_q : a_q;
        r_o    <= d0_q ? W2'($signed(x1_q)) : ov_q ? '0
                : rs_q ? -rem_q[W2-1:0] : rem_q[W2-1:0];
        div0_o <= d0_q;
        ovf_o  <= ov_q;
      end
    end
endmodule

// File: tb/tb_rad2_div_seq.sv
// tb_rad2_div_seq: directed and random checks of rad2_div_seq against a truncating-division model
module tb_rad2_div_seq;
  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, div0_o, ovf_o;
  logic [7:0] x1_i = '0, x2_i = '0, q_o, r_o;
  logic [17:0] expq[$];
  logic [17:0] got;
  int total = 0, bad = 0;

  rad2_div_seq #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x1_i(x1_i), .x2_i(x2_i), .out_valid(out_valid), .out_ready(out_ready),
    .q_o(q_o), .r_o(r_o), .div0_o(div0_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // result packed as {div0, ovf, q[7:0], r[7:0]}
  function automatic logic [17:0] model(input int a, input int b);
    int q, r;
    logic d0, ov;
    d0 = (b == 0);
    ov = (a == -128 && b == -1);
    if (d0) begin q = -1; r = a; end
    else if (ov) begin q = -128; r = 0; end
    else begin q = a / b; r = a % b; end
    return {d0, ov, q[7:0], r[7:0]};
  endfunction

  always @(negedge clk)
    if (!reset && out_valid) begin
      chk("in_ready_while_done", {31'b0, in_ready}, 32'd0);
      if (expq.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else chk("result", {14'b0, div0_o, ovf_o, q_o, r_o}, {14'b0, expq[0]});
    end

  // called at a negedge; returns at a negedge after the result handshake
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold, output logic [17:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    x1_i = a; x2_i = b; in_valid = 1'b1;
    @(posedge clk);
    expq.push_back(model(int'($signed(a)), int'($signed(b))));
    n = 0;
    do begin @(negedge clk); in_valid = 1'b0; n++; end while (!out_valid && n < 40);
    chk("latency", n, 32'd10);
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      in_valid = i[0]; x1_i = 8'h33; x2_i = 8'h01;
      @(negedge clk);
    end
    in_valid = 1'b0;
    res = {div0_o, ovf_o, q_o, r_o};
    out_ready = 1'b1;
    @(posedge clk);
    if (expq.size() > 0) void'(expq.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {20'b0, q_o, r_o, div0_o, ovf_o, out_valid, in_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("model_100_7", {14'b0, model(100, 7)}, {14'b0, 2'b00, 8'h0E, 8'h02});
    chk("model_m100_7", {14'b0, model(-100, 7)}, {14'b0, 2'b00, 8'hF2, 8'hFE});
    chk("model_m128_m1", {14'b0, model(-128, -1)}, {14'b0, 2'b01, 8'h80, 8'h00});
    chk("model_5_0", {14'b0, model(5, 0)}, {14'b0, 2'b10, 8'hFF, 8'h05});
    do_op(8'd100, 8'd7, 0, got);
    chk("100/7", {14'b0, got}, {14'b0, 2'b00, 8'h0E, 8'h02});
    do_op(8'h9C, 8'd7, 0, got);
    chk("-100/7", {14'b0, got}, {14'b0, 2'b00, 8'hF2, 8'hFE});
    do_op(8'd100, 8'hF9, 0, got);
    chk("100/-7", {14'b0, got}, {14'b0, 2'b00, 8'hF2, 8'h02});
    do_op(8'h9C, 8'hF9, 0, got);
    chk("-100/-7", {14'b0, got}, {14'b0, 2'b00, 8'h0E, 8'hFE});
    do_op(8'h80, 8'hFF, 0, got);
    chk("-128/-1", {14'b0, got}, {14'b0, 2'b01, 8'h80, 8'h00});
    do_op(8'h80, 8'h01, 0, got);
    chk("-128/1", {14'b0, got}, {14'b0, 2'b00, 8'h80, 8'h00});
    do_op(8'd5, 8'h00, 0, got);
    chk("5/0", {14'b0, got}, {14'b0, 2'b10, 8'hFF, 8'h05});
    do_op(8'd77, 8'd10, 20, got);
    chk("hold_77/10", {14'b0, got}, {14'b0, 2'b00, 8'h07, 8'h07});
    repeat (12) @(negedge clk);
    chk("no_ghost_op", {30'b0, in_ready, out_valid}, 32'd2);
    x1_i = 8'd50; x2_i = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midop_reset", {20'b0, q_o, r_o, div0_o, ovf_o, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(8'd9, 8'd3, 0, got);
    chk("9/3_after_reset", {14'b0, got}, {14'b0, 2'b00, 8'h03, 8'h00});
    for (int k = 0; k < 1000; k++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: b = 8'h80;
        2: b = 8'hFF;
        3: b = 8'h01;
        default: b = 8'($urandom_range(0, 255));
      endcase
      do_op(a, b, $urandom_range(0, 3), got);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
